// File: rtl/if_id_buffer.sv
// IF-to-ID pipeline buffer: in-order queue of fetched {pc, pc_next, instruction}
// entries with decode-side valid/ready handshake, flush, and entry-time flags.
module if_id_buffer #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_pc_next,
   input  logic [ILEN-1:0]          in_instruction,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_pc_next,
   output logic [ILEN-1:0]          out_instruction,
   output logic                     out_misaligned,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 2 * XLEN + ILEN + 2;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          push, pop, write_en;
   logic [EW-1:0] entry_in, head;

   assign in_ready  = (count_q != FULL_C);
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   // A flushed push never lands, so storage only sees entries that will be read.
   assign write_en = push & ~flush;

   assign entry_in = {in_pc, in_pc_next, in_instruction,
                      (in_pc[1:0] != 2'b00), (in_instruction[1:0] != 2'b11)};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (write_en) mem_q[wr_ptr_q] <= entry_in;
   end

   // Empty queue presents all-zero data so stale storage never leaks to decode.
   assign head = out_valid ? mem_q[rd_ptr_q] : '0;

   assign out_pc          = head[EW-1 -: XLEN];
   assign out_pc_next     = head[EW-XLEN-1 -: XLEN];
   assign out_instruction = head[ILEN+1 : 2];
   assign out_misaligned  = head[1];
   assign out_illegal     = head[0];

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomized scoreboard bench for if_id_buffer with directed scenarios up front.
module tb_if_id_buffer;

   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 2;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcn;
      logic [ILEN-1:0] ins;
      logic            mis;
      logic            ill;
   } entry_t;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic [XLEN-1:0]        in_pc = '0;
   logic [XLEN-1:0]        in_pc_next = '0;
   logic [ILEN-1:0]        in_instruction = '0;
   logic                   flush = 1'b0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [XLEN-1:0]        out_pc;
   logic [XLEN-1:0]        out_pc_next;
   logic [ILEN-1:0]        out_instruction;
   logic                   out_misaligned;
   logic                   out_illegal;
   logic [$clog2(DEPTH):0] count;

   int     n_vec = 0;
   int     n_err = 0;
   entry_t exp_q[$];
   bit     exp_ready = 1'b1;

   if_id_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_pc_next(in_pc_next), .in_instruction(in_instruction),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_pc_next(out_pc_next), .out_instruction(out_instruction),
      .out_misaligned(out_misaligned), .out_illegal(out_illegal),
      .count(count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) assert (count <= DEPTH) else $error("count above DEPTH");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Output-side monitor: checks the head against the model and retires popped entries.
   always begin
      @(negedge clk);
      #2;
      if (!reset) begin
         exp_q.delete();
         exp_ready = 1'b1;
      end else begin
         chk("count", 64'(count), 64'(exp_q.size()));
         chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         exp_ready = (exp_q.size() != DEPTH);
         if (exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_pc_next", out_pc_next, exp_q[0].pcn);
            chk("out_instruction", 64'(out_instruction), 64'(exp_q[0].ins));
            chk("out_misaligned", 64'(out_misaligned), 64'(exp_q[0].mis));
            chk("out_illegal", 64'(out_illegal), 64'(exp_q[0].ill));
            if (out_ready) begin
               $display("pop pc=%h pc_next=%h ins=%h mis=%0b ill=%0b",
                        exp_q[0].pc, exp_q[0].pcn, exp_q[0].ins, exp_q[0].mis, exp_q[0].ill);
               void'(exp_q.pop_front());
            end
         end else begin
            chk("empty_pc", out_pc, 64'd0);
            chk("empty_pc_next", out_pc_next, 64'd0);
            chk("empty_ins", 64'(out_instruction), 64'd0);
            chk("empty_flags", 64'({out_misaligned, out_illegal}), 64'd0);
         end
      end
   end

   // Input-side tracker: records each accepted fetch as an expected response.
   always begin
      entry_t e;
      @(negedge clk);
      #4;
      if (reset) begin
         if (flush) begin
            exp_q.delete();
         end else if (in_valid && exp_ready) begin
            e.pc  = in_pc;
            e.pcn = in_pc_next;
            e.ins = in_instruction;
            e.mis = (in_pc % 4) != 0;
            e.ill = (in_instruction % 4) != 3;
            exp_q.push_back(e);
         end
      end
   end

   task automatic drive(input bit v, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins,
                        input bit ordy, input bit fl);
      @(negedge clk);
      in_valid       = v;
      in_pc          = pc;
      in_pc_next     = pc + 64'd4;
      in_instruction = ins;
      out_ready      = ordy;
      flush          = fl;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_pc", out_pc, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // single push, then back-pressure with a rejected third push
      drive(1, 64'd8,  32'h00500093, 0, 0);
      drive(1, 64'd12, 32'h00000013, 0, 0);
      drive(1, 64'd16, 32'h00000013, 0, 0);
      drive(0, 64'd0,  32'h0, 0, 0);
      drive(0, 64'd0,  32'h0, 1, 0);
      drive(0, 64'd0,  32'h0, 1, 0);

      // streaming: one-cycle latency, count holds at 1
      for (int i = 0; i < 4; i++) drive(1, 64'(4 * i), 32'h00000013, 1, 0);
      drive(0, 64'd0, 32'h0, 1, 0);

      // flush with a simultaneous push and pop
      drive(1, 64'd8,  32'h00000013, 0, 0);
      drive(1, 64'd12, 32'h00000013, 0, 0);
      drive(1, 64'd16, 32'h00000013, 1, 1);
      drive(0, 64'd0,  32'h0, 1, 0);

      // flags on misaligned pc and compressed encoding
      drive(1, 64'd6, 32'h00000001, 0, 0);
      drive(0, 64'd0, 32'h0, 1, 0);

      // asynchronous reset between edges
      drive(1, 64'd8,  32'h00000013, 0, 0);
      drive(1, 64'd12, 32'h00000013, 0, 0);
      drive(0, 64'd0,  32'h0, 0, 0);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("async_out_valid", 64'(out_valid), 64'd0);
      chk("async_count", 64'(count), 64'd0);
      chk("async_out_pc", out_pc, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("release_in_ready", 64'(in_ready), 64'd1);

      // randomized traffic; idle cycles carry garbage on the data inputs
      for (int i = 0; i < 400; i++) begin
         logic [XLEN-1:0] rpc;
         logic [ILEN-1:0] rins;
         rpc  = {$urandom, $urandom};
         rins = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) rins[1:0] = 2'b11;
         drive($urandom_range(0, 3) != 0, rpc, rins,
               $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      end

      repeat (4) drive(0, 64'd0, 32'h0, 1, 0);
      @(negedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Instruction-fetch-to-decode pipeline buffer. Sits directly downstream of the IF stage.
- Captures each fetched {pc, pc_next, instruction} triple into a small in-order queue and presents it to the decode stage over a valid/ready handshake.
- Supports back-pressure from decode and a synchronous flush for branch/jump redirects.
- Flags misaligned PCs and non-32-bit encodings at entry.

Parameters:
XLEN, 64, width of pc and pc_next
ILEN, 32, instruction width
DEPTH, 2, queue entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = reset asserted)
in_valid  input  1  IF stage has a fetched instruction this cycle
in_ready  output  1  buffer can accept an entry this cycle
in_pc  input  XLEN  PC of the fetched instruction
in_pc_next  input  XLEN  sequential next PC produced by IF (pc+4)
in_instruction  input  ILEN  fetched instruction word
flush  input  1  discard all held entries and any same-cycle push
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode accepts the head entry
out_pc  output  XLEN  head entry PC
out_pc_next  output  XLEN  head entry next PC
out_instruction  output  ILEN  head entry instruction
out_misaligned  output  1  head entry pc[1:0] != 2'b00
out_illegal  output  1  head entry instruction[1:0] != 2'b11
count  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0; rd/wr pointers=0.
  - out_valid=0; all out_* data = 0.
  - in_ready=1 once reset deasserts.
  - Storage contents don't care.
- Reset assertion mid-operation drops all entries immediately, without waiting for a clock edge.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated at the rising edge.
- in_ready = (count != DEPTH).
  - Combinational from registered count only; never depends on out_ready.
  - When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0).
- out_pc, out_pc_next, out_instruction, out_misaligned, out_illegal:
  - Come from the head entry.
  - Forced to 0 when count==0.
- No bypass. An entry pushed at edge N is first visible at out_* after edge N, so latency is 1 cycle.
- Entry flags are computed at push time from the in_* fields and stored with the entry:
  - misaligned = in_pc[1:0] != 0
  - illegal = in_instruction[1:0] != 2'b11
- Occupancy update:
  - push & !pop: count+1
  - pop & !push: count-1
  - push & pop: count unchanged
- Pointers are DEPTH-modulo and wrap naturally. FIFO order is strict.
- flush=1 at an edge:
  - count=0 and pointers=0 after that edge.
  - Any same-cycle push is discarded.
  - A same-cycle pop is still considered consumed by decode (decode sees out_valid=1, out_ready=1 and takes the entry).
  - flush has priority over push.
- in_pc_next is carried unmodified; no arithmetic is done on it.
- X on in_* while in_valid=0 must not propagate into storage or flags.
- Overflow and underflow are impossible by construction. A bench assertion checks count <= DEPTH.

Test Plan:
- Reset then single push:
  - Stimulus: reset=0 for 2 cycles, release; push in_pc=8, in_pc_next=12, in_instruction=32'h00500093.
  - Response: next cycle out_valid=1, out_pc=8, out_pc_next=12, out_illegal=0, out_misaligned=0, count=1.
- Fill and back-pressure:
  - Stimulus: out_ready=0; push pc=8, 12, 16.
  - Response: after 2 pushes count=2 and in_ready=0; pc=16 is not accepted. out_pc stays 8 until out_ready=1. Pops then yield 8, then 12.
- Streaming:
  - Stimulus: out_ready=1, in_valid=1 every cycle, pc=0, 4, 8, 12.
  - Response: out_pc=0, 4, 8, 12 on consecutive cycles, each 1 cycle after push; count stays 1; pointers wrap without gaps.
- Flush with simultaneous push:
  - Stimulus: count=2 (pc 8, 12); out_ready=1 while in_valid=1 (pc=16) and flush=1 in the same cycle.
  - Response: count=0 and out_valid=0 next cycle; pc=16 is never output.
- Flags:
  - Stimulus: push pc=6 with instruction 32'h00000001.
  - Response: out_misaligned=1, out_illegal=1; pc=6 is output unchanged.
- Async reset mid-stream:
  - Stimulus: count=2, then drive reset=0 between clock edges.
  - Response: out_valid=0, count=0 and out_pc=0 immediately (before the next edge); in_ready=1 after release.
